// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared state codes, hex font and polarity helper for the scanner
package sevenseg_pkg;

    localparam logic [0:0] ST_GAP   = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Active-high abc_defg patterns, entry 15 first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1110011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// rtl/scan_divider.sv - free-running slot divider, tick marks the last cycle of each slot
module scan_divider
    import sevenseg_pkg::*;
#(
    parameter int DIV_BITS = 16,
    parameter int DIV_MAX  = 49999
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] div_d;

    assign tick = (div_q == DIV_BITS'(DIV_MAX));

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// rtl/sevenseg_scanner.sv - time-multiplexed seven-segment scanner
// Frame-synchronous value commit, per-slot dead time and leading-zero blanking.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV_BITS       = 16,
    parameter int DIV_MAX        = 49999,
    parameter int GHOST_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DIGITS*4-1:0] value,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic                blank_zeros,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic              SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_INV}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW != 0}};

    logic                tick;
    logic                boundary;
    logic                zero_run;
    logic                lit;
    logic                dp_req;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   sel_oh;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [0:0]          state_q, state_d;
    logic [DIV_BITS-1:0] gap_q, gap_d;
    logic [DIGITS*4-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                disp_bz_q, disp_bz_d, pend_bz_q, pend_bz_d;
    logic                pend_flag_q, pend_flag_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    scan_divider #(
        .DIV_BITS (DIV_BITS),
        .DIV_MAX  (DIV_MAX)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        boundary = tick && (idx_q == IDX_LAST);

        idx_d   = idx_q;
        state_d = state_q;
        gap_d   = gap_q;
        if (tick) begin
            idx_d   = boundary ? '0 : idx_q + IDX_W'(1);
            state_d = (GHOST_CYCLES == 0) ? ST_DRIVE : ST_GAP;
            gap_d   = '0;
        end else if (state_q == ST_GAP) begin
            if (32'(gap_q) + 32'd1 >= 32'(GHOST_CYCLES)) begin
                state_d = ST_DRIVE;
            end else begin
                gap_d = gap_q + DIV_BITS'(1);
            end
        end

        // A load on the boundary tick goes straight to the display so it is not lost a frame.
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_bz_d   = disp_bz_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_bz_d   = pend_bz_q;
        pend_flag_d = pend_flag_q;
        if (boundary && load) begin
            disp_val_d  = value;
            disp_dp_d   = dp_mask;
            disp_bz_d   = blank_zeros;
            pend_flag_d = 1'b0;
        end else if (boundary && pend_flag_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            disp_bz_d   = pend_bz_q;
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_mask;
            pend_bz_d   = blank_zeros;
            pend_flag_d = 1'b1;
        end

        zero_run = disp_bz_d;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_val_d[4*i +: 4] == 4'h0);
            blank[i] = (i != 0) && zero_run;
        end

        lit    = 1'b0;
        digit  = 4'h0;
        dp_req = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit  = disp_val_d[4*i +: 4];
                dp_req = disp_dp_d[i];
                lit    = (state_d == ST_DRIVE) && !blank[i];
            end
        end

        sel_oh       = lit ? (DIGITS'(1) << idx_d) : '0;
        an_d         = sel_oh ^ AN_OFF;
        seg_d        = seg_polarity(lit ? HEX_SEG[digit] : 7'h00, SEG_INV);
        dp_d         = (lit && dp_req) ^ SEG_INV;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            state_q      <= ST_GAP;
            gap_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_bz_q    <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_bz_q    <= 1'b0;
            pend_flag_q  <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= SEG_INV;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            state_q      <= state_d;
            gap_q        <= gap_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_bz_q    <= disp_bz_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_bz_q    <= pend_bz_d;
            pend_flag_q  <= pend_flag_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// tb/tb_sevenseg_scanner.sv - scoreboard bench for sevenseg_scanner against a cycle-count model
module tb_sevenseg_scanner;

    localparam int SLOT  = 4;
    localparam int GHOST = 1;
    localparam int FRAME = 16;

    typedef struct {
        int         tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        blank_zeros = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   checked = 0;
    int   n = 0;

    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp;
    logic        m_bz, p_bz, p_flag;

    sevenseg_scanner #(
        .DIGITS         (4),
        .DIV_BITS       (4),
        .DIV_MAX        (3),
        .GHOST_CYCLES   (1),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: font = 7'b1111110;  4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;  4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;  4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;  4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;  4'h9: font = 7'b1110011;
            4'hA: font = 7'b1110111;  4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;  4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;  default: font = 7'b1000111;
        endcase
    endfunction

    // Expected pins for cycle cyc counted from reset release, from slot arithmetic only.
    function automatic exp_t model_out(input int cyc);
        exp_t        e;
        int          pos;
        int          idx;
        logic [15:0] upper;
        logic        lit;
        pos   = cyc % SLOT;
        idx   = (cyc / SLOT) % 4;
        upper = m_val >> (4 * idx);
        lit   = (pos >= GHOST) && !(m_bz && idx > 0 && upper == 16'h0);
        e.tag = cyc;
        e.an  = lit ? ~(4'b0001 << idx) : 4'b1111;
        e.seg = lit ? ~font(upper[3:0]) : 7'b1111111;
        e.dp  = !(lit && m_dp[idx]);
        e.fd  = (cyc > 0) && (cyc % FRAME == 0);
        return e;
    endfunction

    function automatic exp_t reset_out();
        exp_t e;
        e.tag = -1;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        m_val = 16'h0; m_dp = 4'h0; m_bz = 1'b0;
        p_val = 16'h0; p_dp = 4'h0; p_bz = 1'b0; p_flag = 1'b0;
        n = 0;
    endtask

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic run_cycle(input logic ld, input logic [15:0] v, input logic [3:0] m, input logic b);
        @(negedge clk);
        push(model_out(n));
        load = ld; value = v; dp_mask = m; blank_zeros = b;
        if (ld) begin
            if (n % FRAME == FRAME - 1) begin
                m_val = v; m_dp = m; m_bz = b; p_flag = 1'b0;
            end else begin
                p_val = v; p_dp = m; p_bz = b; p_flag = 1'b1;
            end
        end else if ((n % FRAME == FRAME - 1) && p_flag) begin
            m_val = p_val; m_dp = p_dp; m_bz = p_bz; p_flag = 1'b0;
        end
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) run_cycle(1'b0, value, dp_mask, blank_zeros);
    endtask

    task automatic idle_to(input int phase);
        for (int k = 0; k < FRAME; k++) begin
            if (n % FRAME == phase) break;
            run_cycle(1'b0, value, dp_mask, blank_zeros);
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        load = 1'b0;
        push(reset_out());
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        for (int d = 0; d < 4; d++) begin
            v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Monitor: one expected entry per cycle, compared half a cycle after the outputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checked++;
                total++;
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    bad++;
                    $display("FAIL pins cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                             e.tag, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                total++;
                if ($countones(~an) > 1) begin
                    bad++;
                    $display("FAIL anode_onehot cyc=%0d got an=%b want at most one low", e.tag, an);
                end
            end
        end
    end

    initial begin
        model_clear();
        #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) reset_cycle();
        release_reset();

        idle(20);
        run_cycle(1'b1, 16'h12AF, 4'b0100, 1'b0);
        idle(40);
        run_cycle(1'b1, 16'h0030, 4'b0000, 1'b1);
        idle(40);

        idle_to(0);
        run_cycle(1'b1, 16'h1111, 4'b0000, 1'b0);
        idle_to(5);
        run_cycle(1'b1, 16'h2222, 4'b0000, 1'b0);
        idle(36);

        idle_to(2);
        run_cycle(1'b1, 16'h3333, 4'b0001, 1'b0);
        idle_to(8);
        run_cycle(1'b1, 16'h4444, 4'b1000, 1'b0);
        idle(36);

        idle_to(FRAME - 1);
        run_cycle(1'b1, 16'h5A5A, 4'b1010, 1'b0);
        idle(20);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0)
                run_cycle(1'b1, rand_value(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                run_cycle(1'b0, value, dp_mask, blank_zeros);
        end

        idle_to(3);
        run_cycle(1'b1, 16'h9999, 4'b1111, 1'b0);
        idle_to(10);
        @(negedge clk);
        reset = 1'b1;
        load = 1'b0;
        push(reset_out());
        reset_cycle();
        reset_cycle();
        release_reset();
        idle(40);

        @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0 || checked != pushed) begin
            bad++;
            $display("FAIL scoreboard_drain got checked=%0d left=%0d want checked=%0d left=0",
                     checked, exp_q.size(), pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
